// File: rtl/spgd_dither_sequencer_pkg.sv
// Shared definitions for the SPGD dither sequencer: state encodings,
// sign-LFSR constants and a width-generic saturating adder.
package spgd_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_APPLY_P  = 3'd1;
    localparam logic [2:0] ST_SETTLE_P = 3'd2;
    localparam logic [2:0] ST_MEAS_P   = 3'd3;
    localparam logic [2:0] ST_APPLY_M  = 3'd4;
    localparam logic [2:0] ST_SETTLE_M = 3'd5;
    localparam logic [2:0] ST_MEAS_M   = 3'd6;
    localparam logic [2:0] ST_UPDATE   = 3'd7;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting right: feedback = b0^b2^b3^b5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // a + b computed one bit wider, clamped to a signed w-bit range.
    // Operands must already fit in 32 bits; callers truncate the result to w.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (w - 1));
        if (sum > hi)
            return 32'(hi);
        else if (sum < lo)
            return 32'(lo);
        else
            return 32'(sum);
    endfunction

endpackage

// File: rtl/spgd_dither_sequencer_if.sv
// Start/done handshake between the sequencer (master) and the ADC averager (slave).
interface spgd_dither_sequencer_if #(
    parameter int AVG_WIDTH = 24
);
    logic                        AVG_START;
    logic                        AVG_DONE;
    logic signed [AVG_WIDTH-1:0] AVG_DATA;

    modport master (output AVG_START, input AVG_DONE, input AVG_DATA);
    modport slave  (input AVG_START, output AVG_DONE, output AVG_DATA);
endinterface

// File: rtl/spgd_dither_sequencer_sign_gen.sv
// Per-iteration dither sign source.
// SPGD_SEQ_LFSR_EN defined: 16-bit Fibonacci LFSR, bit0 -> s_A, bit1 -> s_B.
// SPGD_SEQ_LFSR_EN undefined: 2-bit iteration counter for deterministic bring-up.
// A sign bit of 1 means +1, 0 means -1. The source steps once per 'advance'.
module spgd_sign_gen
    import spgd_pkg::*;
(
    input  logic ADC_CLK,
    input  logic RST_N,
    input  logic advance,
    output logic s_A,
    output logic s_B
);

`ifdef SPGD_SEQ_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    // shift in the tap parity when an iteration completes
    always_comb begin
        lfsr_d = lfsr_q;
        if (advance)
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end

    // LFSR register, restarts from the seed on reset
    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign s_A = lfsr_q[0];
    assign s_B = lfsr_q[1];
`else
    logic [1:0] cnt_q, cnt_d;

    // count completed iterations
    always_comb begin
        cnt_d = cnt_q;
        if (advance)
            cnt_d = cnt_q + 2'd1;
    end

    // iteration counter register
    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= 2'd0;
        else        cnt_q <= cnt_d;
    end

    assign s_A = cnt_q[0];
    assign s_B = cnt_q[1];
`endif

endmodule

// File: rtl/spgd_dither_sequencer.sv
// SPGD iteration sequencer: dithers both DAC channels, requests one ADC
// average per polarity, then steps the base codes along the measured gradient.
// Sign source selected by SPGD_SEQ_LFSR_EN (see spgd_sign_gen).
//
//   state    | meaning
//   IDLE     | DACs hold base, waiting for ENABLE
//   APPLY_P  | load DAC = sat(base + s*dither)
//   SETTLE_P | wait SETTLE_CYCLES+1 cycles
//   MEAS_P   | pulse AVG_START, capture J+ on AVG_DONE
//   APPLY_M  | load DAC = sat(base - s*dither)
//   SETTLE_M | wait SETTLE_CYCLES+1 cycles
//   MEAS_M   | pulse AVG_START, capture J- on AVG_DONE
//   UPDATE   | base += s*step, DAC = base, pulse ITER_DONE
module spgd_dither_sequencer
    import spgd_pkg::*;
#(
    parameter int DAC_WIDTH    = 14,
    parameter int AVG_WIDTH    = 24,
    parameter int SETTLE_WIDTH = 16
) (
    input  logic                        ADC_CLK,
    input  logic                        RST_N,
    input  logic                        ENABLE,
    input  logic [DAC_WIDTH-2:0]        DITHER,
    input  logic [SETTLE_WIDTH-1:0]     SETTLE_CYCLES,
    input  logic [4:0]                  GAIN_SHIFT,
    spgd_dither_sequencer_if.master     avg_if,
    output logic signed [DAC_WIDTH-1:0] DACA_CODE_OUT,
    output logic signed [DAC_WIDTH-1:0] DACB_CODE_OUT,
    output logic signed [AVG_WIDTH:0]   DJ_OUT,
    output logic                        ITER_DONE,
    output logic                        BUSY,
    output logic [2:0]                  FSM_STATE
);

    logic [2:0]                  state_q, state_d;
    logic [SETTLE_WIDTH-1:0]     cnt_q, cnt_d;
    logic signed [DAC_WIDTH-1:0] base_a_q, base_a_d, base_b_q, base_b_d;
    logic signed [DAC_WIDTH-1:0] dac_a_q, dac_a_d, dac_b_q, dac_b_d;
    logic signed [AVG_WIDTH-1:0] jp_q, jp_d, jm_q, jm_d;
    logic signed [AVG_WIDTH:0]   dj_q, dj_d;
    logic                        start_q, start_d, done_q, done_d;

    logic                        s_a, s_b, advance;
    logic signed [31:0]          dith_w, off_a, off_b, step_w;
    logic signed [AVG_WIDTH:0]   jp_x, jm_x, dj_w, shifted_w;
    logic signed [DAC_WIDTH-1:0] app_a, app_b, upd_a, upd_b;

    spgd_sign_gen u_sign_gen (
        .ADC_CLK (ADC_CLK),
        .RST_N   (RST_N),
        .advance (advance),
        .s_A     (s_a),
        .s_B     (s_b)
    );

    // dithered codes for the current APPLY phase and the gradient step
    always_comb begin
        dith_w = signed'(32'(DITHER));
        off_a  = s_a ? dith_w : -dith_w;
        off_b  = s_b ? dith_w : -dith_w;
        if (state_q == ST_APPLY_M) begin
            off_a = -off_a;
            off_b = -off_b;
        end
        app_a = DAC_WIDTH'(sat_add(32'(base_a_q), off_a, DAC_WIDTH));
        app_b = DAC_WIDTH'(sat_add(32'(base_b_q), off_b, DAC_WIDTH));

        jp_x      = {jp_q[AVG_WIDTH-1], jp_q};
        jm_x      = {jm_q[AVG_WIDTH-1], jm_q};
        dj_w      = jp_x - jm_x;
        // shifts past the width leave only sign bits: 0 or -1
        shifted_w = dj_w >>> GAIN_SHIFT;
        step_w    = sat_add(32'(shifted_w), 32'sd0, DAC_WIDTH);
        upd_a     = DAC_WIDTH'(sat_add(32'(base_a_q), s_a ? step_w : -step_w, DAC_WIDTH));
        upd_b     = DAC_WIDTH'(sat_add(32'(base_b_q), s_b ? step_w : -step_w, DAC_WIDTH));
    end

    // sequencing FSM; dropping ENABLE returns the DACs to base without an update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        dac_a_d  = dac_a_q;
        dac_b_d  = dac_b_q;
        jp_d     = jp_q;
        jm_d     = jm_q;
        dj_d     = dj_q;
        start_d  = 1'b0;
        done_d   = 1'b0;
        advance  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ENABLE) state_d = ST_APPLY_P;
            end
            ST_APPLY_P, ST_APPLY_M: begin
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                    dac_a_d = base_a_q;
                    dac_b_d = base_b_q;
                end else begin
                    dac_a_d = app_a;
                    dac_b_d = app_b;
                    cnt_d   = SETTLE_CYCLES;
                    state_d = (state_q == ST_APPLY_P) ? ST_SETTLE_P : ST_SETTLE_M;
                end
            end
            ST_SETTLE_P, ST_SETTLE_M: begin
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                    dac_a_d = base_a_q;
                    dac_b_d = base_b_q;
                end else if (cnt_q == '0) begin
                    state_d = state_q + 3'd1;
                    start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - SETTLE_WIDTH'(1);
                end
            end
            ST_MEAS_P, ST_MEAS_M: begin
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                    dac_a_d = base_a_q;
                    dac_b_d = base_b_q;
                end else if (avg_if.AVG_DONE && !start_q) begin
                    // a done pulse in the request cycle belongs to an older request
                    if (state_q == ST_MEAS_P) begin
                        jp_d    = avg_if.AVG_DATA;
                        state_d = ST_APPLY_M;
                    end else begin
                        jm_d    = avg_if.AVG_DATA;
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                base_a_d = upd_a;
                base_b_d = upd_b;
                dac_a_d  = upd_a;
                dac_b_d  = upd_b;
                dj_d     = dj_w;
                done_d   = 1'b1;
                advance  = 1'b1;
                state_d  = ENABLE ? ST_APPLY_P : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            dac_a_q  <= '0;
            dac_b_q  <= '0;
            jp_q     <= '0;
            jm_q     <= '0;
            dj_q     <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            dac_a_q  <= dac_a_d;
            dac_b_q  <= dac_b_d;
            jp_q     <= jp_d;
            jm_q     <= jm_d;
            dj_q     <= dj_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    assign avg_if.AVG_START = start_q;
    assign DACA_CODE_OUT    = dac_a_q;
    assign DACB_CODE_OUT    = dac_b_q;
    assign DJ_OUT           = dj_q;
    assign ITER_DONE        = done_q;
    assign BUSY             = (state_q != ST_IDLE);
    assign FSM_STATE        = state_q;

endmodule
